dec_issue: RTL
==============

Name: dec_issue

Overview:
Decode/issue stage sitting directly upstream of EXE.
- Accepts packed 18-bit instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each word into EXE's operand fields (oper, reg0, reg1, reg2, data, imm) and drives them from registers, one instruction per cycle.
- EXE has no valid input, so every idle, stalled or illegal cycle drives a bubble: oper=000, imm=0, reg0=reg1=reg2=0, data=0. Destination register 0 is EXE's discard target.

Parameters:
DEPTH, 4, instruction FIFO entries (power of two, ≥2)
INSTR_W, 18, instruction word width (fixed encoding below)

Ports:
i_clk  input  1  clock, rising edge
i_rsn  input  1  asynchronous active-low reset
i_instr  input  18  instruction word
i_valid  input  1  i_instr valid
o_ready  output  1  FIFO can accept a word
i_stall  input  1  hold issue; outputs forced to bubble
o_oper  output  3  to EXE i_oper
o_reg0  output  4  to EXE i_reg0 (source 0)
o_reg1  output  4  to EXE i_reg1 (source 1)
o_reg2  output  4  to EXE i_reg2 (destination)
o_data  output  6  to EXE i_data, signed immediate
o_imm  output  1  to EXE i_imm
o_issue  output  1  outputs carry a real instruction this cycle
o_illegal  output  1  one-cycle pulse: illegal word discarded
o_count  output  3  FIFO occupancy, 0..DEPTH

Behaviour:
- Encoding:
  - [17:15] oper; [14] imm; [13:10] dst → reg2; [9:6] src0 → reg0.
  - imm=1: [5:0] → o_data; o_reg1=0.
  - imm=0: [3:0] → o_reg1; o_data=0; [5:4] must be 00.
- Illegal word: oper ∈ {110, 111}, or imm=0 with [5:4]≠00.
- Reset (i_rsn=0, asynchronous, any time including mid-burst):
  - FIFO empties; pointers and count go to 0.
  - All o_* fields go to bubble; o_issue=0, o_illegal=0, o_ready=0.
  - o_ready goes high on the first rising edge after i_rsn rises.
- Push: i_valid & o_ready at a rising edge writes the word at the write pointer. Pointer wraps modulo DEPTH.
- o_ready = !full, a registered-state function. It is never combinational from i_valid or i_stall.
- Pop: FIFO not empty & !i_stall at a rising edge reads the head and loads the output registers with its decoded fields.
  - Legal head: o_issue=1.
  - Illegal head: outputs load bubble, o_issue=0, o_illegal=1 for that cycle. The word is consumed, not retried.
- No pop (empty or i_stall): output registers load bubble, o_issue=0, o_illegal=0.
- Latency: a word accepted at edge N into an empty FIFO appears on the outputs after edge N+1. Back-to-back pops give one instruction per cycle.
- Simultaneous push and pop:
  - Allowed whenever not full; count unchanged, both pointers advance.
  - When full, push is blocked by o_ready=0. A pop in that cycle frees a slot; o_ready rises for the next cycle.
- Empty: no pop and no underflow; the head is never read.
- Full: i_valid while full is ignored and the word is not written. The upstream must hold it.
- Stall: FIFO contents and order are preserved. Issue resumes at the first edge with i_stall=0 and the FIFO non-empty.
- o_count = pushes − pops since reset, registered.
- No RAW hazard logic: EXE writes its register file at the issue edge, so dependent back-to-back instructions are legal.

Decomposition:
- Shared package dec_pkg holds:
  - field position constants (OPER_HI/LO, IMM_BIT, DST/SRC0/SRC1/DATA ranges);
  - opcode constants (OP_ADD=000, OP_SUB=001, OP_SHIFT=010, OP_AND=011, OP_OR=100, OP_XOR=101);
  - bubble constant values.
- One sub-module, dec_fifo: parameterised DEPTH × INSTR_W FIFO with push/pop, full/empty and count.
- Decode and output registers stay in dec_issue.

Test Plan:
- Reset mid-burst: push 3 words, assert i_rsn=0 between edges → outputs bubble immediately, o_count=0; o_ready=1 one edge after release.
- Push 18'h04402 (load r1=2) into empty FIFO at edge N → after edge N+1: o_oper=000, o_imm=1, o_reg2=1, o_data=2, o_issue=1; next cycle bubble.
- Push 18'h00C42 (r3=r1+r2) → o_imm=0, o_reg0=1, o_reg1=2, o_reg2=3, o_data=0, o_issue=1.
- Fill with i_stall=1: 4 pushes → o_count=4, o_ready=0, 5th word ignored, outputs bubble. Release stall → 4 issues on consecutive cycles in push order; o_ready rises after the first pop.
- Push 18'h30000 (oper=110) → o_illegal=1 for one cycle, o_issue=0, bubble outputs. Same for 18'h00030 (imm=0, [5:4]=11).
- Continuous i_valid with i_stall toggling every cycle over 20 words → every word issued exactly once, in order; o_count never exceeds 4.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared field layout, opcodes and decode helpers for the decode/issue stage.
// Instruction words are 18 bits: oper | imm | dst | src0 | src1-or-data.
package dec_pkg;

  localparam int INSTR_WIDTH = 18;

  localparam int OPER_HI = 17;
  localparam int OPER_LO = 15;
  localparam int IMM_BIT = 14;
  localparam int DST_HI  = 13;
  localparam int DST_LO  = 10;
  localparam int SRC0_HI = 9;
  localparam int SRC0_LO = 6;
  localparam int PAD_HI  = 5;
  localparam int PAD_LO  = 4;
  localparam int SRC1_HI = 3;
  localparam int SRC1_LO = 0;
  localparam int DATA_HI = 5;
  localparam int DATA_LO = 0;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_SHIFT = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;

  typedef struct packed {
    logic [2:0] oper;
    logic       imm;
    logic [3:0] reg0;
    logic [3:0] reg1;
    logic [3:0] reg2;
    logic [5:0] data;
  } exe_t;

  localparam exe_t BUBBLE = '0;

  function automatic logic is_illegal(
    input logic [INSTR_WIDTH-1:0] w
  );
    logic [2:0] op;
    logic       ok_op;
    op    = w[OPER_HI:OPER_LO];
    ok_op = op inside {OP_ADD, OP_SUB, OP_SHIFT,
                       OP_AND, OP_OR, OP_XOR};
    return !ok_op ||
           (!w[IMM_BIT] && (w[PAD_HI:PAD_LO] != 2'b00));
  endfunction

  function automatic exe_t decode(
    input logic [INSTR_WIDTH-1:0] w
  );
    exe_t e;
    e      = BUBBLE;
    e.oper = w[OPER_HI:OPER_LO];
    e.imm  = w[IMM_BIT];
    e.reg2 = w[DST_HI:DST_LO];
    e.reg0 = w[SRC0_HI:SRC0_LO];
    if (e.imm) e.data = w[DATA_HI:DATA_LO];
    else       e.reg1 = w[SRC1_HI:SRC1_LO];
    return e;
  endfunction

endpackage

// File: rtl/dec_fifo.sv
// Instruction buffer: DEPTH x W ring with occupancy count.
// Ready stays low until the first edge after reset release.
module dec_fifo
  import dec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = INSTR_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rsn,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_ready,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          live_q, live_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    live_d   = 1'b1;
    if (i_push) begin
      mem_d[wr_ptr_q] = i_wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (i_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({i_push, i_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_empty = (count_q == '0);
  assign o_ready = live_q && (count_q != CW'(DEPTH));
  assign o_count = count_q;

endmodule

// File: rtl/dec_issue.sv
// Decode/issue stage feeding EXE: buffers words, decodes the head,
// and drives registered operand fields or a bubble every cycle.
module dec_issue
  import dec_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = INSTR_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rsn,
  input  logic [INSTR_W-1:0]     i_instr,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_stall,
  output logic [2:0]             o_oper,
  output logic [3:0]             o_reg0,
  output logic [3:0]             o_reg1,
  output logic [3:0]             o_reg2,
  output logic [5:0]             o_data,
  output logic                   o_imm,
  output logic                   o_issue,
  output logic                   o_illegal,
  output logic [$clog2(DEPTH):0] o_count
);

  logic [INSTR_W-1:0] head;
  logic               empty;
  logic               push;
  logic               pop;
  logic               bad;

  exe_t out_q, out_d;
  logic issue_q, issue_d;
  logic illegal_q, illegal_d;

  assign push = i_valid && o_ready;
  assign pop  = !empty && !i_stall;

  dec_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rsn   (i_rsn),
    .i_push  (push),
    .i_wdata (i_instr),
    .i_pop   (pop),
    .o_rdata (head),
    .o_ready (o_ready),
    .o_empty (empty),
    .o_count (o_count)
  );

  assign bad = is_illegal(head);

  // Illegal heads are consumed and reported, never retried.
  always_comb begin
    out_d     = BUBBLE;
    issue_d   = 1'b0;
    illegal_d = 1'b0;
    unique case (1'b1)
      (pop && bad):  illegal_d = 1'b1;
      (pop && !bad): begin
        out_d   = decode(head);
        issue_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      out_q     <= BUBBLE;
      issue_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      issue_q   <= issue_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_oper    = out_q.oper;
  assign o_imm     = out_q.imm;
  assign o_reg0    = out_q.reg0;
  assign o_reg1    = out_q.reg1;
  assign o_reg2    = out_q.reg2;
  assign o_data    = out_q.data;
  assign o_issue   = issue_q;
  assign o_illegal = illegal_q;

endmodule
